// File: rtl/aes_inv_key_expand.sv
// AES-128 inverse key schedule: starts from the round-10 key and walks
// back to the cipher key, one round key per accepted handshake.

// Forward AES S-box, one byte, pure lookup.
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign y = SBOX[a];
endmodule

module aes_inv_key_expand (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] last_key,
    input  logic         key_ready,
    output logic [127:0] round_key,
    output logic [3:0]   round_idx,
    output logic         key_valid,
    output logic         busy,
    output logic         done
);
    typedef enum logic {IDLE, GEN} state_t;

    state_t      state;
    logic [7:0]  rcon;
    logic [7:0]  rcon_next;
    logic [31:0] w0, w1, w2, w3;
    logic [31:0] p0, p1, p2, p3;
    logic [31:0] rot;
    logic [31:0] sub;
    logic [127:0] prev_key;

    assign w0 = round_key[127:96];
    assign w1 = round_key[95:64];
    assign w2 = round_key[63:32];
    assign w3 = round_key[31:0];

    // Undo the forward recurrence w[i] = w[i-4] ^ w[i-1]: the upper three
    // words of the previous key fall out of plain XORs, and p3 is the
    // previous key's last word, which feeds the RotWord/SubWord step for p0.
    assign p3  = w3 ^ w2;
    assign p2  = w2 ^ w1;
    assign p1  = w1 ^ w0;
    assign rot = {p3[23:0], p3[31:24]};

    aes_sbox u_sbox0 (.a(rot[31:24]), .y(sub[31:24]));
    aes_sbox u_sbox1 (.a(rot[23:16]), .y(sub[23:16]));
    aes_sbox u_sbox2 (.a(rot[15:8]),  .y(sub[15:8]));
    aes_sbox u_sbox3 (.a(rot[7:0]),   .y(sub[7:0]));

    assign p0       = w0 ^ sub ^ {rcon, 24'h0};
    assign prev_key = {p0, p1, p2, p3};

    // Inverse of xtime: divide by x in GF(2^8) modulo 0x11b.
    always_comb begin
        rcon_next = rcon >> 1;
        if (rcon[0]) begin
            rcon_next = ((rcon ^ 8'h1b) >> 1) | 8'h80;
        end
    end

    // Control FSM and registered datapath/outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            round_key <= '0;
            round_idx <= '0;
            key_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rcon      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        round_key <= last_key;
                        round_idx <= 4'd10;
                        rcon      <= 8'h36;
                        key_valid <= 1'b1;
                        busy      <= 1'b1;
                        state     <= GEN;
                    end
                end
                GEN: begin
                    if (key_ready) begin
                        if (round_idx == 4'd0) begin
                            done      <= 1'b1;
                            key_valid <= 1'b0;
                            busy      <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            round_key <= prev_key;
                            round_idx <= round_idx - 4'd1;
                            rcon      <= rcon_next;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_inv_key_expand.sv
// Self-checking bench for aes_inv_key_expand. The reference model expands
// cipher keys forward (FIPS-197 style) with an algebraically built S-box.
module tb_aes_inv_key_expand;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [127:0] last_key = '0;
    logic         key_ready = 1'b0;
    logic [127:0] round_key;
    logic [3:0]   round_idx;
    logic         key_valid;
    logic         busy;
    logic         done;

    aes_inv_key_expand dut (
        .clk(clk), .rst_n(rst_n), .start(start), .last_key(last_key),
        .key_ready(key_ready), .round_key(round_key), .round_idx(round_idx),
        .key_valid(key_valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [7:0]   sb [256];
    logic [127:0] mdl [11];
    logic [7:0]   frc [11];
    logic [127:0] got [11];
    logic [127:0] fips_got [11];

    typedef struct {
        logic [3:0]   idx;
        logic [127:0] key;
    } vec_t;
    vec_t vecs [3];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, want);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [31:0] subrot(input logic [31:0] t);
        logic [31:0] r = {t[23:0], t[31:24]};
        return {sb[r[31:24]], sb[r[23:16]], sb[r[15:8]], sb[r[7:0]]};
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h01;
            for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(x));
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                    ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    // Forward key expansion; fills mdl[0..10] and frc[1..10].
    task automatic expand(input logic [127:0] ck);
        logic [31:0] w [44];
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = ck[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            logic [31:0] t = w[i-1];
            if (i % 4 == 0) begin
                t = subrot(t) ^ {rc, 24'h0};
                frc[i/4] = rc;
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) mdl[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Starts a sequence at the current negedge and follows it to done.
    task automatic run_seq(input logic [127:0] lk, input int stall_at, input int stall_n,
                           input int busy_at, input bit chk_rcon);
        int exp_idx = 10;
        int cyc = 0;
        start = 1'b1;
        last_key = lk;
        key_ready = 1'b1;
        @(negedge clk);
        cyc++;
        while (exp_idx >= 0) begin
            start = 1'b0;
            chk("valid", key_valid, 1'b1);
            chk("busy", busy, 1'b1);
            chk("idx", round_idx, exp_idx[3:0]);
            chk($sformatf("key r%0d", exp_idx), round_key, mdl[exp_idx]);
            if (chk_rcon && exp_idx > 0)
                chk($sformatf("rcon r%0d", exp_idx - 1), dut.rcon, frc[exp_idx]);
            got[exp_idx] = round_key;
            if (exp_idx == stall_at) begin
                key_ready = 1'b0;
                repeat (stall_n) begin
                    @(negedge clk);
                    cyc++;
                    chk("stall idx", round_idx, exp_idx[3:0]);
                    chk("stall key", round_key, got[exp_idx]);
                    chk("stall valid", key_valid, 1'b1);
                end
                key_ready = 1'b1;
            end
            if (exp_idx == busy_at) begin
                start = 1'b1;
                last_key = ~lk;
            end
            @(negedge clk);
            cyc++;
            exp_idx--;
        end
        start = 1'b0;
        last_key = lk;
        chk("done pulse", done, 1'b1);
        chk("done valid", key_valid, 1'b0);
        chk("done busy", busy, 1'b0);
        chk("latency", cyc, 12 + ((stall_at >= 0) ? stall_n : 0));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        build_sbox();

        vecs[0] = '{idx: 4'd10, key: 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        vecs[1] = '{idx: 4'd9,  key: 128'hac7766f319fadc2128d12941575c006e};
        vecs[2] = '{idx: 4'd0,  key: 128'h2b7e151628aed2a6abf7158809cf4f3c};

        // Reset values
        #3;
        chk("rst key", round_key, '0);
        chk("rst idx", round_idx, '0);
        chk("rst valid", key_valid, 1'b0);
        chk("rst busy", busy, 1'b0);
        chk("rst done", done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // FIPS-197 A.1 with rcon probe, plus table of published round keys
        expand(128'h2b7e151628aed2a6abf7158809cf4f3c);
        run_seq(vecs[0].key, -1, 0, -1, 1'b1);
        for (int i = 0; i < 11; i++) fips_got[i] = got[i];
        for (int i = 0; i < 3; i++)
            chk($sformatf("fips r%0d", vecs[i].idx), got[vecs[i].idx], vecs[i].key);

        // IDLE holds the last key
        @(negedge clk);
        chk("idle key", round_key, vecs[2].key);
        chk("idle valid", key_valid, 1'b0);
        chk("idle done", done, 1'b0);

        // Backpressure at round 6 for 5 cycles
        run_seq(vecs[0].key, 6, 5, -1, 1'b0);
        chk("bp r5", got[5], fips_got[5]);
        chk("bp r0", got[0], fips_got[0]);

        // Start while busy at round 4, then a start in the done cycle
        run_seq(vecs[0].key, -1, 0, 4, 1'b0);
        run_seq(vecs[0].key, -1, 0, -1, 1'b0);

        // Asynchronous reset at round 3
        @(negedge clk);
        start = 1'b1;
        last_key = vecs[0].key;
        key_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!(key_valid && round_idx == 4'd3) && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("reach r3", round_idx, 4'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst valid", key_valid, 1'b0);
        chk("arst busy", busy, 1'b0);
        chk("arst done", done, 1'b0);
        chk("arst idx", round_idx, '0);
        chk("arst key", round_key, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post rst valid", key_valid, 1'b0);
        run_seq(vecs[0].key, -1, 0, -1, 1'b1);

        // Random round-trip, back to back
        for (int t = 0; t < 100; t++) begin
            expand({$urandom, $urandom, $urandom, $urandom});
            run_seq(mdl[10], -1, 0, -1, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
